// File: rtl/fcvt_i2f_seq.sv
// Integer-to-single conversion sequencer: accepts FCVT.S.W/WU requests, drives the shared
// signed-only converter for one cycle, extends it to unsigned operands and returns a registered result.
module fcvt_i2f_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_unsigned,
    input  logic [31:0] in_int,
    input  logic [2:0]  in_rm,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  frm,
    output logic [31:0] cvt_int,
    output logic [2:0]  cvt_rm,
    input  logic [31:0] cvt_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_fflags,
    output logic        out_illegal
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    localparam logic [2:0] RmRtz = 3'b001;

    state_e      state_q, state_d;
    logic [31:0] op_q, op_d;
    logic        exp_fix_q, exp_fix_d;
    logic [2:0]  rm_q, rm_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  rd_q, rd_d;
    logic        nx_q, nx_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        out_ill_q, out_ill_d;

    logic        accept;
    logic [2:0]  eff_rm;
    logic [31:0] mag;
    logic [4:0]  msb;
    logic        nx_calc;

    // Inexact detection on the true magnitude: any set bit below the 24-bit mantissa window.
    always_comb begin
        mag = (!in_unsigned && in_int[31]) ? (~in_int + 32'd1) : in_int;
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        nx_calc = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i] && (i + 23 < int'(msb))) nx_calc = 1'b1;
        end
    end

    assign eff_rm = (in_rm == 3'b111) ? frm : in_rm;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        exp_fix_d = exp_fix_q;
        rm_d      = rm_q;
        illegal_d = illegal_q;
        rd_d      = rd_q;
        nx_d      = nx_q;
        result_d  = result_q;
        out_rd_d  = out_rd_q;
        fflags_d  = fflags_q;
        out_ill_d = out_ill_q;

        in_ready = !flush && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
        accept   = in_valid && in_ready;

        if (accept) begin
            // WU operands above 2^31-1 are halved with a sticky LSB; exponent restored after.
            if (in_unsigned && in_int[31]) begin
                op_d      = {1'b0, in_int[31:2], in_int[1] | in_int[0]};
                exp_fix_d = 1'b1;
            end else begin
                op_d      = in_int;
                exp_fix_d = 1'b0;
            end
            illegal_d = (eff_rm == 3'b101) || (eff_rm == 3'b110) || (eff_rm == 3'b111);
            rm_d      = illegal_d ? RmRtz : eff_rm;
            rd_d      = in_rd;
            nx_d      = nx_calc;
        end

        if ((state_q == StConv) && !flush) begin
            if (illegal_q) begin
                result_d = '0;
                fflags_d = '0;
            end else begin
                result_d = cvt_result + (exp_fix_q ? 32'h0080_0000 : 32'h0);
                fflags_d = {4'b0000, nx_q};
            end
            out_ill_d = illegal_q;
            out_rd_d  = rd_q;
        end

        unique case (state_q)
            StIdle: if (accept) state_d = StConv;
            StConv: state_d = StDone;
            StDone: if (out_ready) state_d = accept ? StConv : StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            exp_fix_q <= 1'b0;
            rm_q      <= RmRtz;
            illegal_q <= 1'b0;
            rd_q      <= '0;
            nx_q      <= 1'b0;
            result_q  <= '0;
            out_rd_q  <= '0;
            fflags_q  <= '0;
            out_ill_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            exp_fix_q <= exp_fix_d;
            rm_q      <= rm_d;
            illegal_q <= illegal_d;
            rd_q      <= rd_d;
            nx_q      <= nx_d;
            result_q  <= result_d;
            out_rd_q  <= out_rd_d;
            fflags_q  <= fflags_d;
            out_ill_q <= out_ill_d;
        end
    end

    assign cvt_int     = (state_q == StConv) ? op_q : 32'h0;
    assign cvt_rm      = (state_q == StConv) ? rm_q : RmRtz;
    assign out_valid   = (state_q == StDone);
    assign out_result  = result_q;
    assign out_rd      = out_rd_q;
    assign out_fflags  = fflags_q;
    assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_fcvt_i2f_seq.sv
// Randomised and directed bench for fcvt_i2f_seq; also models the shared signed converter.
module tb_fcvt_i2f_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_unsigned = 1'b0;
    logic [31:0] in_int = '0;
    logic [2:0]  in_rm = '0;
    logic [4:0]  in_rd = '0;
    logic [2:0]  frm = '0;
    logic [31:0] cvt_int;
    logic [2:0]  cvt_rm;
    logic [31:0] cvt_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [4:0]  out_fflags;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcvt_i2f_seq dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_unsigned(in_unsigned), .in_int(in_int), .in_rm(in_rm), .in_rd(in_rd), .frm(frm),
        .cvt_int(cvt_int), .cvt_rm(cvt_rm), .cvt_result(cvt_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_fflags(out_fflags), .out_illegal(out_illegal)
    );

    // Exact rounding of sign/magnitude to binary32; returns {inexact, bits}.
    function automatic logic [32:0] ref_f32(input logic s, input logic [31:0] m,
                                            input logic [2:0] rm);
        longint unsigned q, rem, half, mm;
        int p, sh;
        logic up;
        logic [7:0] e;
        if (m == 0) return 33'h0;
        mm = longint'(m);
        p = 31;
        while (!m[p]) p--;
        if (p <= 23) begin
            q = mm << (23 - p);
            rem = 0;
            half = 1;
        end else begin
            sh = p - 23;
            q = mm >> sh;
            rem = mm % (64'd1 << sh);
            half = 64'd1 << (sh - 1);
        end
        case (rm)
            3'b001:  up = 1'b0;
            3'b010:  up = s && (rem != 0);
            3'b011:  up = !s && (rem != 0);
            3'b100:  up = (rem >= half) && (rem != 0);
            default: up = (rem > half) || ((rem == half) && (rem != 0) && q[0]);
        endcase
        q = q + longint'(up);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
        end
        e = 8'(p + 127);
        return {rem != 0, s, e, q[22:0]};
    endfunction

    function automatic logic [31:0] conv_model(input logic [31:0] x, input logic [2:0] rm);
        logic [32:0] r;
        r = ref_f32(x[31], x[31] ? (~x + 32'd1) : x, rm);
        return r[31:0];
    endfunction

    assign cvt_result = conv_model(cvt_int, cvt_rm);

    // Drives one request from idle and waits (bounded) for out_valid; does not retire it.
    task automatic send(input logic u, input logic [31:0] x, input logic [2:0] rm,
                        input logic [2:0] fr, input logic [4:0] rd, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_unsigned = u; in_int = x; in_rm = rm; frm = fr; in_rd = rd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_result, out_rd, out_fflags, out_illegal} !== 44'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b r=%h rd=%0d ff=%b il=%0b want all 0",
                     out_valid, out_result, out_rd, out_fflags, out_illegal);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    typedef struct {
        logic        u;
        logic [31:0] x;
        logic [2:0]  rm;
        logic [2:0]  fr;
        logic [31:0] res;
        logic [4:0]  ff;
        logic        il;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        int lat;
        v[0]  = '{1'b0, 32'h0000_0007, 3'b000, 3'b000, 32'h40E0_0000, 5'd0, 1'b0};
        v[1]  = '{1'b0, 32'h0100_0001, 3'b000, 3'b000, 32'h4B80_0000, 5'd1, 1'b0};
        v[2]  = '{1'b0, 32'h0100_0001, 3'b011, 3'b000, 32'h4B80_0001, 5'd1, 1'b0};
        v[3]  = '{1'b1, 32'hFFFF_FFFF, 3'b000, 3'b000, 32'h4F80_0000, 5'd1, 1'b0};
        v[4]  = '{1'b1, 32'hFFFF_FFFF, 3'b001, 3'b000, 32'h4F7F_FFFF, 5'd1, 1'b0};
        v[5]  = '{1'b1, 32'h8000_0000, 3'b000, 3'b000, 32'h4F00_0000, 5'd0, 1'b0};
        v[6]  = '{1'b0, 32'h8000_0000, 3'b000, 3'b000, 32'hCF00_0000, 5'd0, 1'b0};
        v[7]  = '{1'b0, 32'hFFFF_FFFF, 3'b000, 3'b000, 32'hBF80_0000, 5'd0, 1'b0};
        v[8]  = '{1'b0, 32'h0000_0000, 3'b000, 3'b000, 32'h0000_0000, 5'd0, 1'b0};
        v[9]  = '{1'b0, 32'h0100_0001, 3'b111, 3'b101, 32'h0000_0000, 5'd0, 1'b1};
        v[10] = '{1'b0, 32'h0100_0003, 3'b111, 3'b001, 32'h4B80_0001, 5'd1, 1'b0};
        v[11] = '{1'b0, 32'h0000_0005, 3'b110, 3'b000, 32'h0000_0000, 5'd0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            send(v[i].u, v[i].x, v[i].rm, v[i].fr, 5'(i + 1), lat);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL dir_latency[%0d] got %0d want 2", i, lat);
            end
            checks++;
            if ({out_result, out_fflags, out_illegal, out_rd} !==
                {v[i].res, v[i].ff, v[i].il, 5'(i + 1)}) begin
                errors++;
                $display("FAIL dir_result[%0d] got r=%h ff=%b il=%b rd=%0d want r=%h ff=%b il=%b rd=%0d",
                         i, out_result, out_fflags, out_illegal, out_rd,
                         v[i].res, v[i].ff, v[i].il, i + 1);
            end
            retire();
        end
    endtask

    task automatic test_random();
        int lat;
        logic u, s, il;
        logic [31:0] x, er;
        logic [2:0] rm, fr, eff;
        logic [4:0] rd;
        logic [32:0] r;
        for (int n = 0; n < 60; n++) begin
            u  = 1'($urandom);
            case ($urandom_range(0, 3))
                0: x = $urandom_range(0, 255);
                1: x = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                2: x = $urandom >> $urandom_range(0, 31);
                default: x = $urandom;
            endcase
            rm = 3'($urandom_range(0, 7));
            fr = 3'($urandom_range(0, 7));
            rd = 5'($urandom);
            eff = (rm == 3'b111) ? fr : rm;
            il = (eff >= 3'd5);
            s = !u && x[31];
            r = ref_f32(s, s ? (~x + 32'd1) : x, eff);
            er = il ? 32'h0 : r[31:0];
            send(u, x, rm, fr, rd, lat);
            checks++;
            if (lat !== 2 || {out_result, out_fflags, out_illegal, out_rd} !==
                {er, 4'b0, r[32] & !il, il, rd}) begin
                errors++;
                $display("FAIL rand[%0d] u=%b x=%h rm=%b frm=%b got lat=%0d r=%h ff=%b il=%b rd=%0d want lat=2 r=%h nx=%b il=%b rd=%0d",
                         n, u, x, rm, fr, lat, out_result, out_fflags, out_illegal, out_rd,
                         er, r[32] & !il, il, rd);
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] held;
        out_ready = 1'b0;
        send(1'b0, 32'h0000_0007, 3'b000, 3'b000, 5'd9, lat);
        held = out_result;
        checks++;
        if (held !== 32'h40E0_0000) begin
            errors++;
            $display("FAIL bp_result got %h want 40e00000", held);
        end
        in_valid = 1'b1; in_int = 32'h0000_0003;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, out_result, out_rd} !== {1'b1, 1'b0, held, 5'd9}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b rdy=%b r=%h rd=%0d want v=1 rdy=0 r=%h rd=9",
                         c, out_valid, in_ready, out_result, out_rd, held);
            end
        end
        in_valid = 1'b0;
        retire();
    endtask

    task automatic test_back_to_back();
        int lat;
        send(1'b0, 32'h0000_0007, 3'b000, 3'b000, 5'd3, lat);
        in_valid = 1'b1; in_unsigned = 1'b1; in_int = 32'h8000_0000; in_rm = 3'b000; in_rd = 5'd4;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_in_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_conv_valid got %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_result, out_rd} !== {1'b1, 32'h4F00_0000, 5'd4}) begin
            errors++;
            $display("FAIL b2b_second got v=%b r=%h rd=%0d want v=1 r=4f000000 rd=4",
                     out_valid, out_result, out_rd);
        end
        retire();
    endtask

    task automatic test_flush();
        @(negedge clk);
        in_valid = 1'b1; in_unsigned = 1'b0; in_int = 32'h0000_0007; in_rm = 3'b000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_conv[%0d] got out_valid=%b want 0", c, out_valid);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_conv();
        int lat;
        send(1'b0, 32'h0100_0001, 3'b011, 3'b000, 5'd17, lat);
        retire();
        @(negedge clk);
        in_valid = 1'b1; in_int = 32'h0000_0007; in_rm = 3'b000; in_rd = 5'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_result, out_rd, out_fflags, out_illegal} !== 44'h0) begin
            errors++;
            $display("FAIL reset_mid_conv got v=%b r=%h rd=%0d ff=%b il=%b want all 0",
                     out_valid, out_result, out_rd, out_fflags, out_illegal);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_lost_op got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
